// File: rtl/e1_rx_liu_mon_pkg.sv
// rtl/e1_rx_liu_mon_pkg.sv - shared FSM encoding, reset constants and helpers for the E1 LIU monitor
package e1_rx_liu_mon_pkg;

  localparam logic [1:0] ST_LOS  = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  localparam logic [7:0] PERIOD_MIN_INIT = 8'd255;
  localparam logic [7:0] PERIOD_MAX_INIT = 8'd0;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/e1_pin_sync.sv
// rtl/e1_pin_sync.sv - N-stage pin synchroniser with rising-edge detect on the synchronised level
module e1_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o
);

  logic [STAGES-1:0] sr_q;
  logic [STAGES-1:0] sr_d;
  logic              prev_q;

  assign sr_d   = {sr_q[STAGES-2:0], pin_i};
  assign sync_o = sr_q[STAGES-1];
  assign rise_o = sr_q[STAGES-1] & ~prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      prev_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      prev_q <= sr_q[STAGES-1];
    end
  end

endmodule

// File: rtl/e1_rx_liu_mon.sv
// rtl/e1_rx_liu_mon.sv - E1 LIU receive monitor: sync, lock FSM, bit tick; period stats under E1_RX_LIU_MON_STATS_EN
module e1_rx_liu_mon
  import e1_rx_liu_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 63,
  parameter int LOCK_EDGES  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pad_rx_data,
  input  logic       pad_rx_clk,
  output logic       out_data,
  output logic       out_valid,
  output logic       tick_rx,
  output logic       lock,
  output logic       los_pulse,
  input  logic       stats_clr,
  output logic [7:0] period_min,
  output logic [7:0] period_max
);

  logic       clk_rise, data_sync, unused_clk_sync, unused_data_rise;
  logic [1:0] state_q, state_d;
  logic [7:0] wd_q, wd_d, acq_q, acq_d, bit_q, bit_d;
  logic       out_data_q, out_data_d, out_valid_q, valid_d;
  logic       tick_q, tick_d, los_q, los_d, timeout;

  e1_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst_n(rst_n), .pin_i(pad_rx_clk), .sync_o(unused_clk_sync), .rise_o(clk_rise)
  );
  e1_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .rst_n(rst_n), .pin_i(pad_rx_data), .sync_o(data_sync), .rise_o(unused_data_rise)
  );

  // Watchdog holds the clk cycles elapsed since the last edge, so at an edge it equals the period.
  assign wd_d    = clk_rise ? 8'd1 : sat_inc8(wd_q);
  assign timeout = (wd_q == 8'(TIMEOUT)) && !clk_rise;
  assign valid_d = clk_rise && (state_q == ST_LOCK);

  always_comb begin
    state_d = state_q;
    acq_d   = acq_q;
    los_d   = 1'b0;
    case (state_q)
      ST_LOS: begin
        if (clk_rise) begin
          state_d = ST_ACQ;
          acq_d   = 8'd1;
        end
      end
      ST_ACQ: begin
        if (clk_rise) begin
          acq_d = acq_q + 8'd1;
          if (acq_q + 8'd1 == 8'(LOCK_EDGES)) state_d = ST_LOCK;
        end else if (timeout) begin
          state_d = ST_LOS;
        end
      end
      ST_LOCK: begin
        if (timeout) begin
          state_d = ST_LOS;
          los_d   = 1'b1;
        end
      end
      default: state_d = ST_LOS;
    endcase
  end

  assign bit_d      = (state_q != ST_LOCK) ? 8'd0 : (valid_d ? bit_q + 8'd1 : bit_q);
  assign tick_d     = valid_d && (bit_q == 8'hFF);
  assign out_data_d = valid_d ? data_sync : out_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOS;
      wd_q        <= 8'd0;
      acq_q       <= 8'd0;
      bit_q       <= 8'd0;
      out_data_q  <= 1'b0;
      out_valid_q <= 1'b0;
      tick_q      <= 1'b0;
      los_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      acq_q       <= acq_d;
      bit_q       <= bit_d;
      out_data_q  <= out_data_d;
      out_valid_q <= valid_d;
      tick_q      <= tick_d;
      los_q       <= los_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign tick_rx   = tick_q;
  assign los_pulse = los_q;
  assign lock      = (state_q == ST_LOCK);

`ifdef E1_RX_LIU_MON_STATS_EN
  logic [7:0] pmin_q, pmin_d, pmax_q, pmax_d;

  always_comb begin
    pmin_d = pmin_q;
    pmax_d = pmax_q;
    if (stats_clr) begin
      pmin_d = PERIOD_MIN_INIT;
      pmax_d = PERIOD_MAX_INIT;
    end else if (valid_d) begin
      if (wd_q < pmin_q) pmin_d = wd_q;
      if (wd_q > pmax_q) pmax_d = wd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmin_q <= PERIOD_MIN_INIT;
      pmax_q <= PERIOD_MAX_INIT;
    end else begin
      pmin_q <= pmin_d;
      pmax_q <= pmax_d;
    end
  end

  assign period_min = pmin_q;
  assign period_max = pmax_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign period_min = 8'd0;
  assign period_max = 8'd0;
`endif

endmodule

// File: tb/tb_e1_rx_liu_mon.sv
// tb/tb_e1_rx_liu_mon.sv - randomized self-checking bench for e1_rx_liu_mon against an edge-level model
module tb_e1_rx_liu_mon;

  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 63;
  localparam int LOCK_EDGES  = 16;
  localparam int LAT         = SYNC_STAGES + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pad_rx_data, pad_rx_clk, stats_clr;
  logic       out_data, out_valid, tick_rx, lock, los_pulse;
  logic [7:0] period_min, period_max;

  e1_rx_liu_mon #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT), .LOCK_EDGES(LOCK_EDGES)) dut (
    .clk(clk), .rst_n(rst_n), .pad_rx_data(pad_rx_data), .pad_rx_clk(pad_rx_clk),
    .out_data(out_data), .out_valid(out_valid), .tick_rx(tick_rx), .lock(lock),
    .los_pulse(los_pulse), .stats_clr(stats_clr), .period_min(period_min), .period_max(period_max)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct { int cyc; int data; int tick; int pmin; int pmax; } vexp_t;
  typedef struct { int cyc; int lvl; } levt_t;
  vexp_t vq[$];
  levt_t lq[$];
  int    losq[$];

  int m_prev, m_have, m_run, m_locked, m_bits, m_min, m_max, m_ticks, m_los;

  function automatic int exp_min();
`ifdef E1_RX_LIU_MON_STATS_EN
    return m_min;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_max();
`ifdef E1_RX_LIU_MON_STATS_EN
    return m_max;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    vq.delete(); lq.delete(); losq.delete();
    m_have = 0; m_run = 0; m_locked = 0; m_bits = 0;
    m_min = 255; m_max = 0; m_ticks = 0; m_los = 0;
  endtask

  task automatic model_los();
    losq.push_back(m_prev + LAT + TIMEOUT);
    lq.push_back('{m_prev + LAT + TIMEOUT, 0});
    m_locked = 0;
    m_los++;
  endtask

  // One pad rising edge driven at cycle n; gaps above TIMEOUT break the run of valid edges.
  task automatic model_edge(input int n, input int b);
    int gap;
    gap = n - m_prev;
    if (m_have != 0 && gap <= TIMEOUT) m_run++;
    else begin
      if (m_locked != 0) model_los();
      m_run = 1;
    end
    if (m_locked != 0) begin
      m_bits++;
      if (gap < m_min) m_min = gap;
      if (gap > m_max) m_max = gap;
      if (m_bits % 256 == 0) m_ticks++;
      vq.push_back('{n + LAT, b, (m_bits % 256 == 0) ? 1 : 0, exp_min(), exp_max()});
    end else if (m_run == LOCK_EDGES) begin
      m_locked = 1;
      m_bits = 0;
      lq.push_back('{n + LAT, 1});
    end
    m_prev = n;
    m_have = 1;
  endtask

  task automatic pad_edge(input int period, input int b);
    int hi;
    hi = period / 2;
    pad_rx_clk  = 1'b1;
    pad_rx_data = b[0];
    model_edge(cyc, b);
    repeat (hi) begin @(posedge clk); #1; end
    pad_rx_clk = 1'b0;
    repeat (period - hi) begin @(posedge clk); #1; end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  bit    mon_en = 1'b0;
  logic  lock_prev = 1'b0;
  int    tick_seen = 0;
  int    los_seen  = 0;
  vexp_t mon_e;
  levt_t mon_l;

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (vq.size() == 0) check("valid_unexpected", int'(out_valid), 0);
        else begin
          mon_e = vq.pop_front();
          check("valid_cycle", cyc, mon_e.cyc);
          check("out_data", int'(out_data), mon_e.data);
          check("tick_rx", int'(tick_rx), mon_e.tick);
          check("period_min", int'(period_min), mon_e.pmin);
          check("period_max", int'(period_max), mon_e.pmax);
        end
      end else if (vq.size() > 0 && vq[0].cyc <= cyc) begin
        check("valid_missing", int'(out_valid), 1);
        vq.delete(0);
      end
      if (tick_rx) tick_seen++;
      if (tick_rx && !out_valid) check("tick_alone", int'(tick_rx), 0);
      if (los_pulse) begin
        los_seen++;
        if (losq.size() == 0) check("los_unexpected", int'(los_pulse), 0);
        else check("los_cycle", cyc, losq.pop_front());
      end else if (losq.size() > 0 && losq[0] <= cyc) begin
        check("los_missing", int'(los_pulse), 1);
        losq.delete(0);
      end
      if (lock != lock_prev) begin
        if (lq.size() == 0) check("lock_unexpected", int'(lock), int'(lock_prev));
        else begin
          mon_l = lq.pop_front();
          check("lock_cycle", cyc, mon_l.cyc);
          check("lock_level", int'(lock), mon_l.lvl);
        end
      end else if (lq.size() > 0 && lq[0].cyc <= cyc) begin
        check("lock_missing", int'(lock), lq[0].lvl);
        lq.delete(0);
      end
    end
    lock_prev <= lock;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_tick_rx"}, int'(tick_rx), 0);
    check({tag, "_lock"}, int'(lock), 0);
    check({tag, "_los_pulse"}, int'(los_pulse), 0);
    check({tag, "_period_min"}, int'(period_min), exp_min());
    check({tag, "_period_max"}, int'(period_max), exp_max());
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; pad_rx_clk = 1'b0; pad_rx_data = 1'b0; stats_clr = 1'b0;
    model_reset();
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(3);
    mon_en = 1'b1;

    // Acquire at period 15 with alternating data, then random traffic plus the exact-timeout gap.
    for (int i = 0; i < LOCK_EDGES + 8; i++) pad_edge(15, (i % 2 == 0) ? 1 : 0);
    check("locked_after_acq", int'(lock), 1);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) pad_edge(TIMEOUT, int'($urandom_range(1, 0)));
      else pad_edge(int'($urandom_range(40, 8)), int'($urandom_range(1, 0)));
    end
    check("locked_after_boundary_gap", int'(lock), 1);

    // Period statistics with alternating 14/16 gaps around a clear.
    pad_edge(14, 1);
    stats_clr = 1'b1; m_min = 255; m_max = 0;
    tick(1);
    stats_clr = 1'b0;
    for (int i = 0; i < 10; i++) pad_edge((i % 2 == 0) ? 16 : 14, i % 2);
    check("stats_min_before_clr", int'(period_min), exp_min());
    check("stats_max_before_clr", int'(period_max), exp_max());
`ifdef E1_RX_LIU_MON_STATS_EN
    check("stats_min_is_14", int'(period_min), 14);
    check("stats_max_is_16", int'(period_max), 16);
`endif
    stats_clr = 1'b1; m_min = 255; m_max = 0;
    tick(1);
    stats_clr = 1'b0;
    check("stats_min_after_clr", int'(period_min), exp_min());
    check("stats_max_after_clr", int'(period_max), exp_max());
    for (int i = 0; i < 6; i++) pad_edge((i % 2 == 0) ? 16 : 14, i % 2);
    check("stats_min_relearn", int'(period_min), exp_min());
    check("stats_max_relearn", int'(period_max), exp_max());

    // Stop the line clock and watch the loss of signal.
    los_seen = 0; m_los = 0;
    model_stop();
    tick(TIMEOUT + 10);
    check("lock_after_stop", int'(lock), 0);
    check("los_count_after_stop", los_seen, m_los);

    // Re-acquire and run 600 locked bits to observe the 256-bit ticks.
    tick_seen = 0; m_ticks = 0;
    for (int i = 0; i < LOCK_EDGES + 600; i++)
      pad_edge(int'($urandom_range(12, 8)), int'($urandom_range(1, 0)));
    check("tick_count_600", tick_seen, m_ticks);
    check("locked_before_reset", int'(lock), 1);

    // Asynchronous reset while locked, then full re-acquisition.
    mon_en = 1'b0;
    model_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    mon_en = 1'b1;
    for (int i = 0; i < LOCK_EDGES - 1; i++) pad_edge(int'($urandom_range(20, 8)), i % 2);
    check("no_lock_at_15_edges", int'(lock), 0);
    pad_edge(10, 1);
    check("relock_at_16_edges", int'(lock), 1);
    for (int i = 0; i < 5; i++) pad_edge(int'($urandom_range(20, 8)), int'($urandom_range(1, 0)));
    tick(10);

    check("valid_queue_drained", vq.size(), 0);
    check("lock_queue_drained", lq.size(), 0);
    check("los_queue_drained", losq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic model_stop();
    if (m_locked != 0) model_los();
  endtask

endmodule

// File: doc/e1_rx_liu_mon.md
E1_RX_LIU_MON -- requirements
Module: e1_rx_liu_mon

Interface
REQ-001 Parameter SYNC_STAGES, default 2, synchroniser depth for the LIU pins (legal 2..4).
REQ-002 Parameter TIMEOUT, default 63, clk cycles without an rx clock edge before clock loss is declared (legal 8..255).
REQ-003 Parameter LOCK_EDGES, default 16, consecutive valid edges needed to declare lock (legal 2..255).
REQ-004 clk  in  1  system clock; all logic is in this single domain.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 pad_rx_data  in  1  raw LIU recovered data pin.
REQ-007 pad_rx_clk  in  1  raw LIU recovered clock pin.
REQ-008 out_data  out  1  sampled E1 bit.
REQ-009 out_valid  out  1  one-cycle strobe qualifying out_data.
REQ-010 tick_rx  out  1  one-cycle pulse every 256 valid bits.
REQ-011 lock  out  1  high while in state LOCK.
REQ-012 los_pulse  out  1  one-cycle pulse on the LOCK->LOS transition.
REQ-013 stats_clr  in  1  clears min/max period statistics.
REQ-014 period_min  out  8  smallest edge-to-edge period in clk cycles since the last clear.
REQ-015 period_max  out  8  largest edge-to-edge period in clk cycles since the last clear.

Function
REQ-016 pad_rx_clk and pad_rx_data each pass through SYNC_STAGES flops; both paths have equal delay.
REQ-017 A rising edge is a synchronised-clock 0->1 transition; data is sampled from the synchronised data in the same cycle.
REQ-018 out_valid pulses, with out_data set, exactly SYNC_STAGES+1 cycles after the pad rising edge, and only in state LOCK.
REQ-019 An 8-bit watchdog counter clears on every edge, otherwise increments and saturates at 255.
REQ-020 FSM states: LOS (reset state), ACQ, LOCK.
REQ-021 LOS->ACQ on any edge; the acquisition edge counter is loaded with 1.
REQ-022 ACQ: each edge increments the edge counter; when it reaches LOCK_EDGES, go to LOCK; watchdog == TIMEOUT goes to LOS.
REQ-023 LOCK: watchdog == TIMEOUT goes to LOS and fires los_pulse in the same cycle as the transition.
REQ-024 An edge and a timeout in the same cycle count as an edge: the watchdog clears and no transition to LOS occurs.
REQ-025 An 8-bit bit counter increments on each out_valid and wraps 255->0; tick_rx pulses together with the out_valid that causes the wrap.
REQ-026 The bit counter is held at 0 outside LOCK, so the first tick_rx comes on the 256th bit after lock.
REQ-027 The period is the watchdog value (saturated) captured at each edge; min/max update only on edges in LOCK.
REQ-028 stats_clr sets period_min=255 and period_max=0; it has priority over a same-cycle update.

Reset
REQ-029 On rst_n low: all synchroniser flops 0, FSM LOS, all counters 0, out_data/out_valid/tick_rx/lock/los_pulse 0, period_min 255, period_max 0.
REQ-030 Reset asserted mid-frame aborts immediately; after release, lock must be re-acquired via LOS->ACQ->LOCK.

Configuration
REQ-031 Macro E1_RX_LIU_MON_STATS_EN: when defined, REQ-027/028 period statistics are implemented.
REQ-032 Without E1_RX_LIU_MON_STATS_EN: period_min drives constant 0, period_max drives constant 0, stats_clr is ignored, and no statistics registers exist.

Structure
REQ-033 A shared package e1_rx_liu_mon_pkg holds the FSM state encoding (LOS=0, ACQ=1, LOCK=2) and the reset constants PERIOD_MIN_INIT=255, PERIOD_MAX_INIT=0.
REQ-034 One sub-module, e1_pin_sync (an N-stage synchroniser with rising-edge detect), is instantiated once per pin.

Verification
REQ-035 Defaults; pad_rx_clk period 15 clk cycles, data alternating 1,0 -> lock rises after the 16th edge; out_valid pulses 3 cycles after each pad edge; out_data alternates.
REQ-036 Locked; clock stopped -> exactly 63 cycles after the last edge the FSM enters LOS, los_pulse fires once, lock=0, out_valid stays 0.
REQ-037 Locked, 600 bits -> tick_rx fires on bits 256 and 512 only.
REQ-038 STATS_EN; periods alternating 14/16 cycles, then stats_clr pulsed -> min=14, max=16; immediately after the clear, 255/0; after the next locked edges, 14/16 again.
REQ-039 Edge arriving in exactly the cycle the watchdog reaches 63 -> no LOS, lock stays 1.
REQ-040 rst_n pulsed low while locked -> all outputs return to their reset values asynchronously; after release, 16 edges are needed to re-lock.
